regx_seq: RTL and testbench
===========================

Name: regx_seq

Overview:
- Sequencer for the largest/second-largest tracking register (regx) and its candidate source (cadder path).
- On a start command it:
  - clears the tracker;
  - streams N candidate addresses to the source;
  - asserts the tracker write enable aligned to the source's fixed latency;
  - drains the pipeline, captures the tracker's largest/second-largest results and pulses done.
- Sits between the frame-level control FSM and the regx/cadder datapath.

Parameters:
- DW, 21, candidate/result data width (matches tracker width).
- AW, 8, candidate address width; also width of num_cand.
- LAT, 2, cycles from cand_rd to valid cadder_out at tracker input; legal range 1..15.
- MINV, 21'h100000, tracker "empty" sentinel (smallest value).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command; sampled only in IDLE.
- num_cand  input  AW  number of candidates N; latched on start.
- single_mode  input  1  1 = track largest only; latched on start.
- hold  input  1  source not ready; pauses address issue.
- abort  input  1  cancel the running job.
- cand_rd  output  1  read strobe to candidate source.
- cand_addr  output  AW  candidate index.
- clear  output  1  to tracker clear.
- wr_en  output  1  to tracker wr_en.
- single  output  1  to tracker single; equals latched single_mode.
- kt  input  1  from tracker; 1 = no write since clear.
- xlout  input  DW  tracker largest.
- xsout  input  DW  tracker second largest.
- busy  output  1  job in progress.
- done  output  1  one-cycle completion pulse.
- best_l  output  DW  captured largest.
- best_s  output  DW  captured second largest.
- s_valid  output  1  best_s is meaningful.
- empty  output  1  no candidate was written (captured kt).

Behaviour:
- States: IDLE, CLR, ISSUE, DRAIN, CAPT, DONE.
- Reset: state=IDLE; cand_rd=0, cand_addr=0, clear=0, wr_en=0, single=0, busy=0, done=0; best_l=best_s=MINV; s_valid=0, empty=1; wr_en delay line all zero.
- IDLE:
  - start=1 latches N and single_mode, then goes to CLR.
  - start in any other state is ignored.
- CLR:
  - clear=1 for exactly one cycle; busy=1 from CLR through DONE.
  - Next state is ISSUE if N>0, else DRAIN.
- ISSUE:
  - Each cycle with hold=0: cand_rd=1, cand_addr=current index, index increments.
  - With hold=0, cand_addr runs 0..N-1 on consecutive cycles; N=2^AW-1 maximum; no wrap.
  - hold=1: cand_rd=0, index and cand_addr held.
  - After issuing index N-1, go to DRAIN.
- wr_en alignment:
  - wr_en(cycle c+LAT) = cand_rd(cycle c), via an LAT-deep shift register.
  - The shift register advances every cycle regardless of hold.
  - clear and wr_en are never high in the same cycle; guaranteed because LAT>=1 and CLR precedes the first cand_rd.
- DRAIN:
  - Counts LAT cycles so the last wr_en is issued, plus one cycle for the tracker update.
  - For N=0, DRAIN lasts one cycle.
- CAPT:
  - best_l<=xlout, best_s<=xsout, empty<=kt.
  - s_valid<=(single_mode==0 && N>=2).
- DONE:
  - done=1 for one cycle, then IDLE with busy=0.
  - best_*, s_valid and empty hold until the next CAPT.
- Latency (no hold, start sampled at edge t):
  - clear high during cycle t+1.
  - cand_rd during t+2..t+N+1.
  - last wr_en at t+N+1+LAT.
  - done at t+N+LAT+4.
  - Each hold cycle during ISSUE adds one cycle.
- Abort:
  - In any non-IDLE state: next state IDLE, delay line flushed (wr_en=0 next cycle), cand_rd=0.
  - No done pulse; best_* unchanged.
  - abort in IDLE has no effect.
  - abort with start in IDLE: start is taken.
- Reset asserted mid-job: all outputs go immediately to their reset values.

Test Plan:
- Dual mode, N=4, LAT=2, candidate values {5,9,3,7} at addr 0..3 -> cand_addr 0,1,2,3 on consecutive cycles; 4 wr_en pulses 2 cycles later; done at t+10; best_l=9, best_s=7, s_valid=1, empty=0.
- Single mode, N=3, values {0x00010,0x00020,0x00005} -> best_l=0x00005 (last written); s_valid=0; single=1 throughout the job.
- N=0 -> clear pulse, no cand_rd or wr_en; done at t+4; empty=1, best_l=best_s=0x100000.
- Dual mode, N=4, hold=1 for 3 cycles after addr 1 -> addr 2 reissued only after hold drops; wr_en count=4; done delayed by 3 cycles; results identical to the first scenario.
- abort during ISSUE at addr 2 -> busy=0 next cycle, no further wr_en, no done; a following start with N=2 runs cleanly.
- reset low during DRAIN -> all outputs at reset values immediately; start after release runs a normal job.

Source files
------------

// File: rtl/regx_seq_if.sv
// Datapath-side bus between the sequencer and the regx tracker / cadder source.
// master = sequencer, slave = datapath (source + tracker).
interface regx_seq_if #(
  parameter int DW = 21,
  parameter int AW = 8
);
  logic          cand_rd;
  logic [AW-1:0] cand_addr;
  logic          clear;
  logic          wr_en;
  logic          single;
  logic          kt;
  logic [DW-1:0] xlout;
  logic [DW-1:0] xsout;

  modport master (
    output cand_rd, cand_addr, clear, wr_en, single,
    input  kt, xlout, xsout
  );

  modport slave (
    input  cand_rd, cand_addr, clear, wr_en, single,
    output kt, xlout, xsout
  );
endinterface

// File: rtl/regx_seq.sv
// Sequencer for the regx largest/second-largest tracker: clears it, streams N
// candidate reads, aligns tracker writes to the source latency, captures results.
module regx_seq #(
  parameter int            DW   = 21,
  parameter int            AW   = 8,
  parameter int            LAT  = 2,
  parameter logic [DW-1:0] MINV = 21'h100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] num_cand,
  input  logic          single_mode,
  input  logic          hold,
  input  logic          abort,
  regx_seq_if.master    dp,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] best_l,
  output logic [DW-1:0] best_s,
  output logic          s_valid,
  output logic          empty
);

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, DRAIN, CAPT, DONE} state_t;

  localparam logic [3:0] LAT4 = 4'(LAT);

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg;
  logic [AW-1:0] n_reg;
  logic          single_reg;
  logic [3:0]    drain_reg;
  logic [LAT-1:0] wr_sr_reg;
  logic          issue;
  logic          flush;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLR;
      CLR:     state_next = (n_reg != '0) ? ISSUE : DRAIN;
      ISSUE:   if (!hold && idx_reg == n_reg - AW'(1)) state_next = DRAIN;
      DRAIN:   if (drain_reg == 4'd0) state_next = CAPT;
      CAPT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

  // Output logic
  always_comb begin
    issue        = (state_reg == ISSUE) && !hold && !abort;
    flush        = abort && (state_reg != IDLE);
    dp.cand_rd   = issue;
    dp.cand_addr = idx_reg;
    dp.clear     = (state_reg == CLR);
    dp.wr_en     = wr_sr_reg[LAT-1];
    dp.single    = single_reg;
    busy         = (state_reg != IDLE);
    done         = (state_reg == DONE) && !abort;
  end

  // wr_en delay line: each stage free-runs, independent of hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     wr_sr_reg[0] <= 1'b0;
    else if (flush) wr_sr_reg[0] <= 1'b0;
    else            wr_sr_reg[0] <= issue;
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_wr_sr
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     wr_sr_reg[gi] <= 1'b0;
        else if (flush) wr_sr_reg[gi] <= 1'b0;
        else            wr_sr_reg[gi] <= wr_sr_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg    <= '0;
      n_reg      <= '0;
      single_reg <= 1'b0;
      drain_reg  <= 4'd0;
      best_l     <= MINV;
      best_s     <= MINV;
      s_valid    <= 1'b0;
      empty      <= 1'b1;
    end else begin
      if (state_reg == IDLE && start) begin
        n_reg      <= num_cand;
        single_reg <= single_mode;
      end
      // DRAIN lasts LAT+1 cycles after issuing, a single cycle for an empty job
      if (state_reg == CLR) begin
        idx_reg   <= '0;
        drain_reg <= (n_reg == '0) ? 4'd0 : LAT4;
      end
      if (issue) idx_reg <= idx_reg + AW'(1);
      if (state_reg == DRAIN && drain_reg != 4'd0) drain_reg <= drain_reg - 4'd1;
      if (state_reg == CAPT && !abort) begin
        best_l  <= dp.xlout;
        best_s  <= dp.xsout;
        empty   <= dp.kt;
        s_valid <= !single_reg && (n_reg >= AW'(2));
      end
    end
  end

endmodule

// File: tb/tb_regx_seq.sv
// Bench for regx_seq: behavioural cadder source and regx tracker, stimulus pushes
// expected job results to a scoreboard that a negedge monitor pops on done.
module tb_regx_seq;
  localparam int            DW   = 21;
  localparam int            AW   = 8;
  localparam int            LAT  = 2;
  localparam logic [DW-1:0] MINV = 21'h100000;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] s;
    logic          sv;
    logic          em;
    int            lat;
    int            n;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_cand = '0;
  logic          single_mode = 1'b0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, s_valid, empty;
  logic [DW-1:0] best_l, best_s;

  regx_seq_if #(.DW(DW), .AW(AW)) bus ();

  regx_seq #(.DW(DW), .AW(AW), .LAT(LAT), .MINV(MINV)) dut (
    .clk(clk), .reset(reset), .start(start), .num_cand(num_cand),
    .single_mode(single_mode), .hold(hold), .abort(abort), .dp(bus),
    .busy(busy), .done(done), .best_l(best_l), .best_s(best_s),
    .s_valid(s_valid), .empty(empty)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   exp_addr = 0;
  logic exp_single = 1'b0;
  exp_t sb[$];

  // Candidate source with LAT-cycle read latency, and the largest/second tracker
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] pipe [0:LAT-1];
  logic [DW-1:0] xl = MINV, xs = MINV;
  logic          kt = 1'b1;
  assign bus.xlout = xl;
  assign bus.xsout = xs;
  assign bus.kt    = kt;

  always @(posedge clk) begin
    cyc++;
    pipe[0] <= bus.cand_rd ? mem[bus.cand_addr] : '0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (bus.clear) begin
      xl <= MINV; xs <= MINV; kt <= 1'b1;
    end else if (bus.wr_en) begin
      kt <= 1'b0;
      if (bus.single) xl <= pipe[LAT-1];
      else if ($signed(pipe[LAT-1]) > $signed(xl)) begin
        xs <= xl; xl <= pipe[LAT-1];
      end else if ($signed(pipe[LAT-1]) > $signed(xs)) xs <= pipe[LAT-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (start && !busy) begin
        start_cyc = cyc; wr_cnt = 0; rd_cnt = 0;
      end
      if (bus.clear) begin
        exp_addr = 0;
        check("clear_wr_excl", 32'(bus.wr_en), 32'd0);
      end
      if (bus.cand_rd) begin
        check("cand_addr", 32'(bus.cand_addr), 32'(exp_addr));
        exp_addr++; rd_cnt++;
      end
      if (bus.wr_en) begin
        wr_cnt++;
        check("single", 32'(bus.single), 32'(exp_single));
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("best_l", 32'(best_l), 32'(e.l));
          check("best_s", 32'(best_s), 32'(e.s));
          check("s_valid", 32'(s_valid), 32'(e.sv));
          check("empty", 32'(empty), 32'(e.em));
          check("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
          check("wr_en_count", 32'(wr_cnt), 32'(e.n));
          check("cand_rd_count", 32'(rd_cnt), 32'(e.n));
          $display("job n=%0d best_l=%0h best_s=%0h s_valid=%0b empty=%0b lat=%0d",
                   e.n, best_l, best_s, s_valid, empty, cyc - start_cyc);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cand_rd"}, 32'(bus.cand_rd), 32'd0);
    check({tag, "_cand_addr"}, 32'(bus.cand_addr), 32'd0);
    check({tag, "_clear"}, 32'(bus.clear), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, "_single"}, 32'(bus.single), 32'd0);
    check({tag, "_best_l"}, 32'(best_l), 32'(MINV));
    check({tag, "_best_s"}, 32'(best_s), 32'(MINV));
    check({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  task automatic push_exp(input int n, input logic [DW-1:0] l, input logic [DW-1:0] s,
                          input logic sv, input logic em, input int lat);
    exp_t e;
    e.n = n; e.l = l; e.s = s; e.sv = sv; e.em = em; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic start_job(input int n, input logic sm);
    @(posedge clk); #1;
    exp_single  = sm;
    start       = 1'b1;
    num_cand    = AW'(n);
    single_mode = sm;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sb(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=pending expected=done", name);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic load4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;

    // Dual mode, N=4
    load4(21'd5, 21'd9, 21'd3, 21'd7);
    push_exp(4, 21'd9, 21'd7, 1'b1, 1'b0, 10);
    start_job(4, 1'b0);
    wait_sb("dual4");

    // Single mode, N=3: tracker keeps last written
    load4(21'h00010, 21'h00020, 21'h00005, 21'd0);
    push_exp(3, 21'h00005, MINV, 1'b0, 1'b0, 9);
    start_job(3, 1'b1);
    wait_sb("single3");

    // N=0: empty job
    push_exp(0, MINV, MINV, 1'b0, 1'b1, 4);
    start_job(0, 1'b0);
    wait_sb("n0");

    // N=1 dual: second largest not meaningful
    load4(21'd7, 21'd0, 21'd0, 21'd0);
    push_exp(1, 21'd7, MINV, 1'b0, 1'b0, 7);
    start_job(1, 1'b0);
    wait_sb("n1");

    // Dual N=4 with hold for 3 cycles after addr 1
    load4(21'd5, 21'd9, 21'd3, 21'd7);
    push_exp(4, 21'd9, 21'd7, 1'b1, 1'b0, 13);
    start_job(4, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (bus.cand_rd && bus.cand_addr == AW'(1)) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_sb("hold");

    // Abort at addr 2
    start_job(4, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (bus.cand_rd && bus.cand_addr == AW'(2)) break;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    wr_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_wr", 32'(wr_cnt), 32'd0);
    check("abort_best_l", 32'(best_l), 32'd9);

    load4(21'd5, 21'd9, 21'd0, 21'd0);
    push_exp(2, 21'd9, 21'd5, 1'b1, 1'b0, 8);
    start_job(2, 1'b0);
    wait_sb("post_abort");

    // Reset asserted during DRAIN
    push_exp(2, 21'd9, 21'd5, 1'b1, 1'b0, 8);
    start_job(2, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_back());
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b1;

    load4(21'd5, 21'd9, 21'd3, 21'd7);
    push_exp(4, 21'd9, 21'd7, 1'b1, 1'b0, 10);
    start_job(4, 1'b0);
    wait_sb("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
